// File: rtl/data_uart_pkg.sv
// Shared constants and state encoding for the 80-bit UART packet link.
// Both the transmit serializer and the byte receiver use uart_state_t.
package data_uart_pkg;

    localparam int DEF_CLKS_PER_BIT      = 100;
    localparam int DEF_NBYTES            = 10;
    localparam int DEF_IDLE_TIMEOUT_BITS = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Synchronizer plus single-byte 8N1 receiver. It emits a one-cycle byte_ok
// or frame_err pulse at mid-stop, and reports when it is idle.
module uart_byte_rx
    import data_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_ok,
    output logic       frame_err,
    output logic       idle
);

    localparam int            CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_reg;
    logic          rx_sync_reg;
    logic          rx_prev_reg;
    uart_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;

    // The synchronizer flops reset to the idle-high line level, so leaving
    // reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_sync_reg && rx_prev_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_sync_reg ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        if (state_reg == STOP && cnt_reg == BIT_LAST) begin
            byte_ok   = rx_sync_reg;
            frame_err = !rx_sync_reg;
        end
        idle      = (state_reg == IDLE);
        byte_data = shift_reg;
    end

endmodule

// File: rtl/data_uart_link.sv
// 80-bit word <-> 10-byte 8N1 UART link, MSB byte first on the wire.
// Holds the TX serializer, the RX packet assembler and the partial-packet timeout.
module data_uart_link
    import data_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT      = DEF_CLKS_PER_BIT,
    parameter int NBYTES            = DEF_NBYTES,
    parameter int IDLE_TIMEOUT_BITS = DEF_IDLE_TIMEOUT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RX,
    input  logic [8*NBYTES-1:0] idata,
    input  logic                senddata,
    output logic [8*NBYTES-1:0] odata,
    output logic                datavalid,
    output logic                TX
);

    localparam int            W         = 8 * NBYTES;
    localparam int            CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BYTE_LAST = 4'(NBYTES - 1);
    localparam int            TO_LIMIT  = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW        = cnt_width(TO_LIMIT);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

    // ---------------- TX serializer ----------------
    uart_state_t   tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]    tx_bit_reg, tx_bit_next;
    logic [3:0]    tx_nbyte_reg, tx_nbyte_next;
    logic [W-1:0]  tx_shift_reg, tx_shift_next;
    logic          tx_reg, tx_next;
    logic [7:0]    tx_cur_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_nbyte_reg <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_nbyte_reg <= tx_nbyte_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_nbyte_next = tx_nbyte_reg;
        tx_shift_next = tx_shift_reg;
        case (tx_state_reg)
            IDLE: begin
                if (senddata) begin
                    tx_state_next = START;
                    tx_shift_next = idata;
                    tx_nbyte_next = '0;
                    tx_cnt_next   = '0;
                end
            end
            START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    tx_bit_next = tx_bit_reg + 3'd1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = STOP;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {tx_shift_reg[W-9:0], 8'h00};
                    if (tx_nbyte_reg == BYTE_LAST) begin
                        tx_nbyte_next = '0;
                        tx_state_next = IDLE;
                    end else begin
                        tx_nbyte_next = tx_nbyte_reg + 4'd1;
                        tx_state_next = START;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: begin
                tx_state_next = IDLE;
            end
        endcase
    end

    // The line level is derived from next-state values so TX is a clean
    // flop output yet changes on the same edge as the FSM.
    always_comb begin
        tx_cur_byte = tx_shift_next[W-1 -: 8];
        case (tx_state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_cur_byte[tx_bit_next];
            default: tx_next = 1'b1;
        endcase
    end

    assign TX = tx_reg;

    // ---------------- RX packet assembler ----------------
    logic [7:0]    rx_byte;
    logic          rx_byte_ok;
    logic          rx_frame_err;
    logic          rx_idle;
    logic [3:0]    rx_nbyte_reg;
    logic [W-1:0]  pkt_reg;
    logic [W-1:0]  odata_reg;
    logic          datavalid_reg;
    logic [TW-1:0] to_cnt_reg;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .byte_data (rx_byte),
        .byte_ok   (rx_byte_ok),
        .frame_err (rx_frame_err),
        .idle      (rx_idle)
    );

    // A partial packet is abandoned on a framing error or after the line
    // has sat idle too long; stale bytes in pkt_reg are shifted out later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_nbyte_reg  <= '0;
            pkt_reg       <= '0;
            odata_reg     <= '0;
            datavalid_reg <= 1'b0;
            to_cnt_reg    <= '0;
        end else begin
            datavalid_reg <= 1'b0;
            if (rx_frame_err) begin
                rx_nbyte_reg <= '0;
                to_cnt_reg   <= '0;
            end else if (rx_byte_ok) begin
                pkt_reg    <= {pkt_reg[W-9:0], rx_byte};
                to_cnt_reg <= '0;
                if (rx_nbyte_reg == BYTE_LAST) begin
                    odata_reg     <= {pkt_reg[W-9:0], rx_byte};
                    datavalid_reg <= 1'b1;
                    rx_nbyte_reg  <= '0;
                end else begin
                    rx_nbyte_reg <= rx_nbyte_reg + 4'd1;
                end
            end else if (rx_idle && rx_nbyte_reg != 4'd0) begin
                if (to_cnt_reg == TO_LAST) begin
                    rx_nbyte_reg <= '0;
                    to_cnt_reg   <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    assign odata     = odata_reg;
    assign datavalid = datavalid_reg;

endmodule

// File: tb/tb_data_uart_link.sv
// Bench for data_uart_link: a waveform-level TX model and a byte-level RX
// packet model feed a scoreboard checked every cycle, plus literal checks.
module tb_data_uart_link;

    localparam int CPB = 100;
    localparam int NB  = 10;
    localparam int TOB = 20;
    localparam int PKT = NB * 10 * CPB;
    localparam logic [79:0] LIT_LOOP  = 80'hFAAF_001F_FFFF_FAAF_AAAA;
    localparam logic [79:0] LIT_FRAME = 80'h0001_0203_0405_0607_0809;
    localparam logic [79:0] LIT_TMO   = 80'h5555_5555_5555_5555_5555;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        senddata = 1'b0;
    logic [79:0] idata = '0;
    logic        rx_line;
    logic [79:0] odata;
    logic        datavalid;
    logic        tx;

    assign rx_line = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    data_uart_link dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx_line),
        .idata     (idata),
        .senddata  (senddata),
        .odata     (odata),
        .datavalid (datavalid),
        .TX        (tx)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state
    logic        m_busy = 1'b0;
    int          m_k    = 0;
    logic [79:0] m_word = '0;
    int          acc_cyc = 0;
    int          m_cnt  = 0;
    logic [79:0] m_pkt  = '0;
    logic [79:0] exp_q[$];
    int          dv_cnt = 0;
    int          dv_cyc = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected line level k cycles after a packet was accepted.
    function automatic logic tx_level(input logic [79:0] w, input int k);
        int         byt;
        int         pos;
        logic [7:0] b;
        byt = k / (10 * CPB);
        pos = (k / CPB) % 10;
        b   = w[79 - 8 * byt -: 8];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos - 1];
    endfunction

    task automatic model_good(input logic [7:0] b);
        m_pkt = {m_pkt[71:0], b};
        m_cnt++;
        if (m_cnt == NB) begin
            exp_q.push_back(m_pkt);
            m_cnt = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else if (m_busy) begin
            m_k++;
            if (m_k == PKT) m_busy = 1'b0;
        end else if (senddata) begin
            m_busy  = 1'b1;
            m_k     = 0;
            m_word  = idata;
            acc_cyc = cyc;
            $display("tx accept %h at cycle %0d", idata, cyc);
            if (loop) exp_q.push_back(idata);
        end
    end

    always @(negedge clk) begin
        logic [79:0] e;
        if (cyc > 1) begin
            chk("tx_line", 80'(tx), 80'(m_busy ? tx_level(m_word, m_k) : 1'b1));
            if (datavalid === 1'b1) begin
                dv_cnt++;
                dv_cyc = cyc;
                $display("rx packet %h at cycle %0d", odata, cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_datavalid: got %0h want none", odata);
                end else begin
                    e = exp_q.pop_front();
                    chk("odata", odata, e);
                end
            end
        end
    end

    task automatic pulse_send(input logic [79:0] w);
        idata    = w;
        senddata = 1'b1;
        @(negedge clk);
        senddata = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop) model_good(b);
        else m_cnt = 0;
        rx_drv = stop;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic gap_bits(input int n);
        rx_drv = 1'b1;
        if (n >= TOB) m_cnt = 0;
        repeat (n * CPB) @(negedge clk);
    endtask

    initial begin
        logic [9:0]  first_frame;
        logic [79:0] w;
        int          d0;
        int          lat;
        int          n;

        first_frame = 10'b1111110100;

        repeat (100) @(negedge clk);
        chk("reset_tx", 80'(tx), 80'(1'b1));
        chk("reset_odata", odata, 80'h0);
        chk("reset_datavalid", 80'(datavalid), 80'(1'b0));
        rst = 1'b0;

        // Loopback with first-byte timing and busy-ignore
        loop = 1'b1;
        d0 = dv_cnt;
        pulse_send(LIT_LOOP);
        for (int k = 1; k < 1000; k++) begin
            @(negedge clk);
            if (k % 100 == 50) chk($sformatf("tx_frame0_bit%0d", k / 100), 80'(tx), 80'(first_frame[k / 100]));
            if (k == 500) begin
                idata    = 80'h1;
                senddata = 1'b1;
            end else begin
                senddata = 1'b0;
            end
        end
        for (int k = 1000; k < PKT + 300; k++) begin
            @(negedge clk);
            if (k == 9050) chk("tx_last_start", 80'(tx), 80'(1'b0));
            if (k == PKT - 1) chk("tx_last_stop", 80'(tx), 80'(1'b1));
        end
        chk("loop_dv_count", 80'(dv_cnt - d0), 80'd1);
        chk("loop_odata", odata, LIT_LOOP);
        lat = dv_cyc - acc_cyc;
        chk("loop_latency", 80'(lat >= 9940 && lat <= 9965), 80'd1);

        // Reset in the middle of a transmission
        w = {16'($urandom), $urandom, $urandom};
        pulse_send(w);
        repeat (3000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("tx_after_rst", 80'(tx), 80'(1'b1));
        chk("dv_after_rst", 80'(datavalid), 80'(1'b0));
        repeat (200) @(negedge clk);
        d0 = dv_cnt;
        w = {16'($urandom), $urandom, $urandom};
        pulse_send(w);
        repeat (PKT + 300) @(negedge clk);
        chk("rst_dv_count", 80'(dv_cnt - d0), 80'd1);
        chk("rst_odata", odata, w);

        // Framing error followed by a good packet
        loop = 1'b0;
        repeat (300) @(negedge clk);
        d0 = dv_cnt;
        send_byte(8'h03, 1'b0);
        gap_bits(2);
        for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b1);
        gap_bits(3);
        chk("frame_dv_count", 80'(dv_cnt - d0), 80'd1);
        chk("frame_odata", odata, LIT_FRAME);

        // Idle timeout resync while TX runs independently
        d0 = dv_cnt;
        pulse_send({16'($urandom), $urandom, $urandom});
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        gap_bits(30);
        for (int i = 0; i < NB; i++) send_byte(8'h55, 1'b1);
        gap_bits(3);
        chk("tmo_dv_count", 80'(dv_cnt - d0), 80'd1);
        chk("tmo_odata", odata, LIT_TMO);

        // Randomized disruption then a random packet
        d0 = dv_cnt;
        n = $urandom_range(1, 9);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
            gap_bits(30);
        end else begin
            send_byte(8'($urandom), 1'b0);
            gap_bits(2);
        end
        for (int i = 0; i < NB; i++) send_byte(8'($urandom), 1'b1);
        gap_bits(3);
        chk("rand_dv_count", 80'(dv_cnt - d0), 80'd1);
        chk("scoreboard_drained", 80'(exp_q.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_uart_link.md
# data_uart_link

Serial packet link that converts an 80-bit parallel word to and from a 10-byte 8N1 UART stream. It transmits `idata` on `TX` when `senddata` is pulsed, and independently assembles 10 received bytes from `RX` into `odata`, flagging completion with `datavalid`. It sits between the host-side encryptor logic (parallel 80-bit words) and an external UART peer (1 Mbaud at a 100 MHz system clock).

## Interface
- `CLKS_PER_BIT`, default 100: system clocks per UART bit (100 MHz / 1 Mbaud).
- `NBYTES`, default 10: bytes per packet; `idata` and `odata` are 8*NBYTES bits wide.
- `IDLE_TIMEOUT_BITS`, default 20: bit times of RX idle inside a partial packet before the receiver discards it.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `RX`  in  1: asynchronous serial input, idle high.
- `idata`  in  80: word to transmit; sampled when `senddata` is accepted.
- `senddata`  in  1: single-cycle transmit request.
- `odata`  out  80: last completely received packet.
- `datavalid`  out  1: one-cycle pulse when `odata` updates.
- `TX`  out  1: serial output, idle high.

## Operation
- Frame format: 8N1 (start 0, 8 data bits LSB first, stop 1), no parity, no gap between bytes.
- Byte order: the MSB byte goes first. TX sends `idata[79:72]` first and `idata[7:0]` last. RX stores its first byte in `odata[79:72]`.
- TX FSM states are IDLE, START, DATA, STOP.
  - In IDLE with `senddata`=1, TX latches `idata` into an 80-bit shift register and clears the byte count.
  - After the 10th stop bit it returns to IDLE.
  - `senddata` while not IDLE is ignored. The latched data is unaffected by later `idata` changes.
- RX front end: a 2-flop synchronizer on `RX`.
- RX FSM states are IDLE, START, DATA, STOP.
  - A falling edge in IDLE enters START.
  - At mid-start (CLKS_PER_BIT/2) the line must still be 0. Otherwise return to IDLE (glitch reject).
  - Data bits are sampled at mid-bit.
  - At mid-stop, a 1 means the byte is accepted and shifted into the packet register. A 0 is a framing error: the byte is dropped and the packet byte count is reset to 0.
- After the 10th accepted byte:
  - `odata` is loaded from the packet register.
  - `datavalid` pulses for one cycle.
  - The byte count resets to 0.
- Idle timeout: if the byte count is nonzero and RX stays in IDLE for IDLE_TIMEOUT_BITS*CLKS_PER_BIT clocks, the byte count resets to 0 and the partial packet is discarded.
- TX and RX are fully independent, so full duplex is supported.

## Timing
- Reset values:
  - `TX`=1, `odata`=0, `datavalid`=0.
  - Both FSMs are IDLE, and all counters and shift registers are 0.
- Reset mid-operation: `TX` reads 1 in the cycle after `rst` is sampled high. Any partial RX packet is lost.
- TX latency: `TX` falls on the first edge after `senddata` is sampled.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - The full packet is NBYTES*10*CLKS_PER_BIT = 10000 cycles.
  - A new `senddata` is accepted on the cycle the FSM is back in IDLE.
- RX latency: `datavalid` asserts 2 (synchronizer) + about CLKS_PER_BIT/2 cycles after the start of the 10th stop bit.
- Counter widths: the bit-time counter needs ⌈log2(CLKS_PER_BIT)⌉ bits. The byte count is 4 bits and wraps only via explicit reset at NBYTES.

## Structure
- Shared package `data_uart_pkg` holds:
  - CLKS_PER_BIT, NBYTES, IDLE_TIMEOUT_BITS defaults.
  - The state enum `uart_state_t` {IDLE, START, DATA, STOP}, used by both FSMs.
- One sub-module is natural: `uart_byte_rx`, a synchronizer plus single-byte receiver with outputs `byte`, `byte_ok` and `frame_err`.
- The top-level holds the packet assembler, the timeout counter and an inline TX serializer.

## Test plan
- Loopback (TX wired to RX): reset for 100 cycles, then pulse `senddata` with `idata`=80'hFAAF_001F_FFFF_FAAF_AAAA. Required: `datavalid` pulses once, about 10000 cycles later, with `odata`=80'hFAAF_001F_FFFF_FAAF_AAAA.
- TX bit timing: with the same stimulus, the first byte on the line is 0 then 0xFA LSB first (0,1,0,1,1,1,1,1) then 1. Each level lasts exactly 100 cycles and the last stop bit ends at cycle 10000.
- Busy ignore: pulse `senddata` with idata=80'h1 at cycle 500 of a transmission. The in-flight packet is unchanged and no second packet is sent.
- Reset mid-TX: assert `rst` at cycle 3000. `TX`=1 the next cycle, and a new `senddata` after reset is transmitted correctly.
- RX framing error: a UART model sends byte 3 with stop=0, then 10 good bytes 0x00..0x09. Exactly one `datavalid`, with `odata`=80'h0001_0203_0405_0607_0809.
- Timeout resync: send 4 bytes, idle 30 bit times, then send 10 bytes of 0x55. One `datavalid`, with `odata`=80'h5555_5555_5555_5555_5555.
